// File: rtl/ecc_tb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package    : ecc_tb_pkg                                                  |
// | Description: Shared types and helpers for the SECDED checker: Hamming    |
// |              parity-bit count, power-of-two test and fail reason codes.  |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
package ecc_tb_pkg;

    // Reason for a failed check; F_NONE marks a passing or idle channel.
    typedef enum logic [3:0] {
        F_NONE     = 4'd0,
        F_NORESP   = 4'd1,
        F_SPURIOUS = 4'd2,
        F_ILLEGAL  = 4'd3,
        F_DATA     = 4'd4,
        F_FLAG0    = 4'd5,
        F_SB       = 4'd6,
        F_DB       = 4'd7,
        F_FIX      = 4'd8
    } fail_code_t;

    // Smallest number of Hamming parity bits m with 2^m >= m + k + 1.
    function automatic int calculate_m(input int k);
        int m;
        m = 0;
        for (int i = 30; i >= 1; i--) begin
            if ((1 << i) >= (i + k + 1)) begin
                m = i;
            end
        end
        return m;
    endfunction

    // True when v has exactly one bit set.
    function automatic logic is_power_of_2(input int unsigned v);
        return (v != 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ecc_chk_delay.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : ecc_chk_delay                                               |
// | Description: Fixed-depth valid + payload shift register. Moves one stage |
// |              every cycle with no backpressure; reset empties it.         |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module ecc_chk_delay #(
    parameter int DEPTH = 2,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_valid,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    output logic [W-1:0] o_data
);

    logic [DEPTH-1:0] r_vld;
    logic [W-1:0]     r_data [DEPTH];

    // Shift the descriptor one stage per cycle; reset drops everything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= '0;
            end
        end else begin
            r_vld[0]  <= i_valid;
            r_data[0] <= i_data;
            for (int i = 1; i < DEPTH; i++) begin
                r_vld[i]  <= r_vld[i-1];
                r_data[i] <= r_data[i-1];
            end
        end
    end

    assign o_valid = r_vld[DEPTH-1];
    assign o_data  = r_data[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/ecc_multi_checker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : ecc_multi_checker                                           |
// | Description: Multi-channel scoreboard for SECDED encoder/decoder pairs.  |
// |              Delays each injected-error descriptor to meet the decoder   |
// |              result, classifies it, and keeps saturating pass/fail       |
// |              counts, sticky per-channel fail flags and a first-failure   |
// |              capture.                                                    |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module ecc_multi_checker
    import ecc_tb_pkg::*;
#(
    parameter int K        = 8,
    parameter int P0_LSB   = 0,
    parameter int CHANNELS = 4,
    parameter int LATENCY  = 2,
    parameter int CNT_W    = 32,
    localparam int c_M     = calculate_m(K),
    localparam int c_N     = c_M + K,
    localparam int c_PW    = $clog2(c_N + 1),
    localparam int c_CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clr_i,
    input  logic [CHANNELS-1:0]      inj_valid_i,
    input  logic [CHANNELS*K-1:0]    inj_d_i,
    input  logic [CHANNELS*2-1:0]    inj_nflips_i,
    input  logic [CHANNELS*c_PW-1:0] inj_flip1_i,
    input  logic [CHANNELS*c_PW-1:0] inj_flip2_i,
    input  logic [CHANNELS-1:0]      dec_valid_i,
    input  logic [CHANNELS*K-1:0]    dec_q_i,
    input  logic [CHANNELS-1:0]      dec_sb_err_i,
    input  logic [CHANNELS-1:0]      dec_db_err_i,
    input  logic [CHANNELS-1:0]      dec_sb_fix_i,
    output logic [CNT_W-1:0]         pass_cnt_o,
    output logic [CNT_W-1:0]         fail_cnt_o,
    output logic [CHANNELS-1:0]      fail_sticky_o,
    output logic                     first_vld_o,
    output logic [c_CH_W-1:0]        first_ch_o,
    output fail_code_t               first_code_o
);

    localparam int                c_DW      = K + 2 + 2 * c_PW;
    localparam int                c_P0_LOC  = (P0_LSB != 0) ? 0 : c_N;
    localparam logic [c_PW-1:0]   c_P0_POS  = c_PW'(c_P0_LOC);
    localparam int                c_PC_W    = $clog2(CHANNELS + 1);
    localparam int                c_SUM_W   = ((CNT_W > c_PC_W) ? CNT_W : c_PC_W) + 1;
    localparam logic [c_SUM_W-1:0] c_CNT_MAX = c_SUM_W'({CNT_W{1'b1}});

    logic [CHANNELS-1:0] w_pass;
    logic [CHANNELS-1:0] w_fail;
    fail_code_t          w_code [CHANNELS];

    logic [c_SUM_W-1:0]  w_pass_pop;
    logic [c_SUM_W-1:0]  w_fail_pop;
    logic [c_SUM_W-1:0]  w_pass_sum;
    logic [c_SUM_W-1:0]  w_fail_sum;
    logic [CNT_W-1:0]    w_pass_next;
    logic [CNT_W-1:0]    w_fail_next;
    logic [c_CH_W-1:0]   w_first_ch;
    fail_code_t          w_first_code;

    logic [CNT_W-1:0]    r_pass_cnt;
    logic [CNT_W-1:0]    r_fail_cnt;
    logic [CHANNELS-1:0] r_sticky;
    logic                r_first_vld;
    logic [c_CH_W-1:0]   r_first_ch;
    fail_code_t          r_first_code;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic            w_stg_vld;
        logic [c_DW-1:0] w_stg_data;
        logic [K-1:0]    w_d;
        logic [1:0]      w_nflips;
        logic [c_PW-1:0] w_flip1;
        logic [c_PW-1:0] w_flip2;
        logic            w_unused_flip2;
        logic            w_exp_sb;
        logic            w_exp_fix;
        logic            w_sb;
        logic            w_db;
        logic            w_fix;
        fail_code_t      w_code_l;

        ecc_chk_delay #(
            .DEPTH (LATENCY),
            .W     (c_DW)
        ) u_delay (
            .clk     (clk_i),
            .rst     (rst_i),
            .i_valid (inj_valid_i[c]),
            .i_data  ({inj_d_i[c*K +: K], inj_nflips_i[c*2 +: 2],
                       inj_flip1_i[c*c_PW +: c_PW], inj_flip2_i[c*c_PW +: c_PW]}),
            .o_valid (w_stg_vld),
            .o_data  (w_stg_data)
        );

        assign {w_d, w_nflips, w_flip1, w_flip2} = w_stg_data;
        // The second flip position travels with the descriptor, but no outcome
        // rule depends on where the second flip landed.
        assign w_unused_flip2 = ^w_flip2;

        assign w_sb  = dec_sb_err_i[c];
        assign w_db  = dec_db_err_i[c];
        assign w_fix = dec_sb_fix_i[c];

        // Classify this channel's check; the first rule that hits sets the code.
        always_comb begin
            w_exp_sb  = (w_flip1 != c_P0_POS);
            w_exp_fix = w_exp_sb && !is_power_of_2((P0_LSB != 0) ? 32'(w_flip1)
                                                                 : 32'(w_flip1) + 32'd1);
            w_code_l  = F_NONE;
            if (!w_stg_vld) begin
                if (dec_valid_i[c]) begin
                    w_code_l = F_SPURIOUS;
                end
            end else if (!dec_valid_i[c]) begin
                w_code_l = F_NORESP;
            end else if ((dec_q_i[c*K +: K] != w_d) && !w_db) begin
                w_code_l = F_DATA;
            end else if (w_nflips == 2'd3) begin
                w_code_l = F_ILLEGAL;
            end else if (w_nflips == 2'd0) begin
                if (w_sb || w_db || w_fix) begin
                    w_code_l = F_FLAG0;
                end
            end else if (w_nflips == 2'd1) begin
                if (w_sb != w_exp_sb) begin
                    w_code_l = F_SB;
                end else if (w_db) begin
                    w_code_l = F_DB;
                end else if (w_fix != w_exp_fix) begin
                    w_code_l = F_FIX;
                end
            end else begin
                if (!w_db) begin
                    w_code_l = F_DB;
                end else if (w_sb) begin
                    w_code_l = F_SB;
                end else if (w_fix) begin
                    w_code_l = F_FIX;
                end
            end
        end

        assign w_fail[c] = (w_code_l != F_NONE);
        assign w_pass[c] = w_stg_vld && (w_code_l == F_NONE);
        assign w_code[c] = w_code_l;
    end : g_ch

    // Count this cycle's events and pick the lowest failing channel.
    always_comb begin
        w_pass_pop   = '0;
        w_fail_pop   = '0;
        w_first_ch   = '0;
        w_first_code = F_NONE;
        for (int c = CHANNELS - 1; c >= 0; c--) begin
            w_pass_pop = w_pass_pop + c_SUM_W'(w_pass[c]);
            w_fail_pop = w_fail_pop + c_SUM_W'(w_fail[c]);
            if (w_fail[c]) begin
                w_first_ch   = c_CH_W'(c);
                w_first_code = w_code[c];
            end
        end
        w_pass_sum  = c_SUM_W'(r_pass_cnt) + w_pass_pop;
        w_fail_sum  = c_SUM_W'(r_fail_cnt) + w_fail_pop;
        w_pass_next = (w_pass_sum > c_CNT_MAX) ? {CNT_W{1'b1}} : w_pass_sum[CNT_W-1:0];
        w_fail_next = (w_fail_sum > c_CNT_MAX) ? {CNT_W{1'b1}} : w_fail_sum[CNT_W-1:0];
    end

    // Statistics registers; clear discards whatever happened in the same cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            r_pass_cnt   <= '0;
            r_fail_cnt   <= '0;
            r_sticky     <= '0;
            r_first_vld  <= 1'b0;
            r_first_ch   <= '0;
            r_first_code <= F_NONE;
        end else begin
            r_pass_cnt <= w_pass_next;
            r_fail_cnt <= w_fail_next;
            r_sticky   <= r_sticky | w_fail;
            if (!r_first_vld && (|w_fail)) begin
                r_first_vld  <= 1'b1;
                r_first_ch   <= w_first_ch;
                r_first_code <= w_first_code;
            end
        end
    end

    assign pass_cnt_o    = r_pass_cnt;
    assign fail_cnt_o    = r_fail_cnt;
    assign fail_sticky_o = r_sticky;
    assign first_vld_o   = r_first_vld;
    assign first_ch_o    = r_first_ch;
    assign first_code_o  = r_first_code;

endmodule
`default_nettype wire

// File: tb/tb_ecc_multi_checker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : tb_ecc_multi_checker                                        |
// | Description: Self-checking bench for ecc_multi_checker. Stimulus drives  |
// |              descriptors and decoder answers; a behavioural model queues |
// |              the expected statistics, a monitor compares them.           |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module tb_ecc_multi_checker;
    import ecc_tb_pkg::*;

    localparam int K       = 8;
    localparam int P0_LSB  = 0;
    localparam int CH      = 4;
    localparam int LAT     = 2;
    localparam int CNT_W   = 6;
    // K=8 SECDED: 4 Hamming parity bits + 8 data bits, overall parity at bit 12.
    localparam int NBITS   = 12;
    localparam int PW      = 4;
    localparam int P0_LOC  = (P0_LSB != 0) ? 0 : NBITS;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam int HIST    = 16;

    typedef struct {
        bit           vld;
        logic [K-1:0] d;
        int           nflips;
        int           f1;
        int           f2;
        int           corrupt;   // 0 none, 1 sb, 2 db, 3 fix, 4 data bit, 5 no response
        int           cbit;
    } desc_t;

    typedef struct {
        int          cyc;
        int          pass;
        int          fail;
        logic [CH-1:0] sticky;
        bit          fvld;
        int          fch;
        int          fcode;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                clr = 1'b0;
    logic [CH-1:0]       inj_valid = '0;
    logic [CH*K-1:0]     inj_d = '0;
    logic [CH*2-1:0]     inj_nflips = '0;
    logic [CH*PW-1:0]    inj_flip1 = '0;
    logic [CH*PW-1:0]    inj_flip2 = '0;
    logic [CH-1:0]       dec_valid = '0;
    logic [CH*K-1:0]     dec_q = '0;
    logic [CH-1:0]       dec_sb = '0;
    logic [CH-1:0]       dec_db = '0;
    logic [CH-1:0]       dec_fix = '0;
    logic [CNT_W-1:0]    pass_cnt;
    logic [CNT_W-1:0]    fail_cnt;
    logic [CH-1:0]       sticky;
    logic                first_vld;
    logic [1:0]          first_ch;
    fail_code_t          first_code;

    int    cyc = 0;
    int    n_cmp = 0;
    int    n_bad = 0;
    int    spur_pct = 0;
    int    last_rst = -1000;
    desc_t hist [CH][HIST];
    desc_t plan_d [CH];
    exp_t  sbq [$];

    int            m_pass = 0;
    int            m_fail = 0;
    logic [CH-1:0] m_sticky = '0;
    bit            m_fvld = 0;
    int            m_fch = 0;
    int            m_fcode = 0;

    ecc_multi_checker #(
        .K        (K),
        .P0_LSB   (P0_LSB),
        .CHANNELS (CH),
        .LATENCY  (LAT),
        .CNT_W    (CNT_W)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .clr_i         (clr),
        .inj_valid_i   (inj_valid),
        .inj_d_i       (inj_d),
        .inj_nflips_i  (inj_nflips),
        .inj_flip1_i   (inj_flip1),
        .inj_flip2_i   (inj_flip2),
        .dec_valid_i   (dec_valid),
        .dec_q_i       (dec_q),
        .dec_sb_err_i  (dec_sb),
        .dec_db_err_i  (dec_db),
        .dec_sb_fix_i  (dec_fix),
        .pass_cnt_o    (pass_cnt),
        .fail_cnt_o    (fail_cnt),
        .fail_sticky_o (sticky),
        .first_vld_o   (first_vld),
        .first_ch_o    (first_ch),
        .first_code_o  (first_code)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Parity positions are those whose 1-based Hamming index has a single bit set.
    function automatic bit pos_is_parity(input int p);
        int hp;
        hp = (P0_LSB != 0) ? p : p + 1;
        return $countones(hp) == 1;
    endfunction

    // Outcome rules, applied in priority order.
    function automatic int ref_code(input desc_t h, input bit dv, input logic [K-1:0] q,
                                    input bit sb, input bit db, input bit fx);
        bit exp_sb;
        bit exp_fx;
        if (!dv) return F_NORESP;
        if ((q != h.d) && !db) return F_DATA;
        if (h.nflips == 3) return F_ILLEGAL;
        exp_sb = (h.f1 != P0_LOC);
        exp_fx = exp_sb && !pos_is_parity(h.f1);
        if (h.nflips == 0) return (sb || db || fx) ? F_FLAG0 : F_NONE;
        if (h.nflips == 1) begin
            if (sb != exp_sb) return F_SB;
            if (db) return F_DB;
            if (fx != exp_fx) return F_FIX;
            return F_NONE;
        end
        if (!db) return F_DB;
        if (sb) return F_SB;
        if (fx) return F_FIX;
        return F_NONE;
    endfunction

    task automatic set_plan(input int c, input logic [K-1:0] d, input int nf, input int f1,
                            input int f2, input int corrupt);
        plan_d[c].vld     = 1'b1;
        plan_d[c].d       = d;
        plan_d[c].nflips  = nf;
        plan_d[c].f1      = f1;
        plan_d[c].f2      = f2;
        plan_d[c].corrupt = corrupt;
        plan_d[c].cbit    = 3;
    endtask

    task automatic rand_plan(input int c, input int corrupt_pct);
        int r;
        plan_d[c].vld = ($urandom_range(0, 99) < 80);
        plan_d[c].d   = K'($urandom);
        r = $urandom_range(0, 99);
        plan_d[c].nflips  = (r < 35) ? 0 : (r < 70) ? 1 : (r < 95) ? 2 : 3;
        plan_d[c].f1      = $urandom_range(0, NBITS);
        plan_d[c].f2      = (plan_d[c].f1 + $urandom_range(1, NBITS)) % (NBITS + 1);
        plan_d[c].corrupt = ($urandom_range(0, 99) < corrupt_pct) ? $urandom_range(1, 5) : 0;
        plan_d[c].cbit    = $urandom_range(0, K - 1);
    endtask

    // One cycle: drive injections and decoder answers, advance the model, queue expectation.
    task automatic tick(input bit do_rst, input bit do_clr);
        int            k;
        int            np;
        int            nf;
        bit            found;
        logic [CH-1:0] fails;
        int            codes [CH];
        exp_t          e;
        k = cyc;
        rst = do_rst;
        clr = do_clr;
        np = 0;
        nf = 0;
        fails = '0;
        for (int c = 0; c < CH; c++) begin
            desc_t        h;
            bit           have;
            bit           stage;
            bit           dv;
            bit           sb;
            bit           db;
            bit           fx;
            logic [K-1:0] q;
            hist[c][k % HIST]      = plan_d[c];
            inj_valid[c]           = plan_d[c].vld;
            inj_d[c*K +: K]        = plan_d[c].d;
            inj_nflips[c*2 +: 2]   = 2'(plan_d[c].nflips);
            inj_flip1[c*PW +: PW]  = PW'(plan_d[c].f1);
            inj_flip2[c*PW +: PW]  = PW'(plan_d[c].f2);
            plan_d[c].vld          = 1'b0;
            have = 1'b0;
            h = plan_d[c];
            if (k >= LAT) begin
                h    = hist[c][(k - LAT) % HIST];
                have = h.vld;
            end
            stage = have && ((k - LAT) > last_rst);
            if (have) begin
                // What a correct decoder reports for this injection.
                dv = 1'b1; q = h.d; sb = 1'b0; db = 1'b0; fx = 1'b0;
                if (h.nflips == 1) begin
                    sb = (h.f1 != P0_LOC);
                    fx = sb && !pos_is_parity(h.f1);
                end else if (h.nflips == 2) begin
                    q  = ~h.d;
                    db = 1'b1;
                end
                case (h.corrupt)
                    1: sb = !sb;
                    2: db = !db;
                    3: fx = !fx;
                    4: q[h.cbit] = !q[h.cbit];
                    5: dv = 1'b0;
                    default: ;
                endcase
            end else begin
                dv = ($urandom_range(0, 99) < spur_pct);
                q  = K'($urandom);
                sb = 1'($urandom); db = 1'($urandom); fx = 1'($urandom);
            end
            if (!dv) begin
                q  = K'($urandom);
                sb = 1'($urandom); db = 1'($urandom); fx = 1'($urandom);
            end
            dec_valid[c]    = dv;
            dec_q[c*K +: K] = q;
            dec_sb[c]       = sb;
            dec_db[c]       = db;
            dec_fix[c]      = fx;
            if (stage) codes[c] = ref_code(h, dv, q, sb, db, fx);
            else       codes[c] = dv ? F_SPURIOUS : F_NONE;
            if (codes[c] != F_NONE) begin
                fails[c] = 1'b1;
                nf++;
            end else if (stage) begin
                np++;
            end
        end
        if (do_rst || do_clr) begin
            m_pass = 0; m_fail = 0; m_sticky = '0; m_fvld = 0; m_fch = 0; m_fcode = F_NONE;
            if (do_rst) last_rst = k;
        end else begin
            m_pass   = (m_pass + np > CNT_MAX) ? CNT_MAX : m_pass + np;
            m_fail   = (m_fail + nf > CNT_MAX) ? CNT_MAX : m_fail + nf;
            m_sticky = m_sticky | fails;
            if (!m_fvld && (fails != '0)) begin
                found = 0;
                for (int c = 0; c < CH; c++) begin
                    if (fails[c] && !found) begin
                        found = 1; m_fch = c; m_fcode = codes[c];
                    end
                end
                m_fvld = 1;
            end
        end
        e.cyc = k; e.pass = m_pass; e.fail = m_fail; e.sticky = m_sticky;
        e.fvld = m_fvld; e.fch = m_fch; e.fcode = m_fcode;
        sbq.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int c, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", nm, c, got, exp);
        end
    endtask

    // Outputs seen in cycle c reflect the events of cycle c-1.
    always @(negedge clk) begin
        exp_t e;
        while (sbq.size() > 0 && sbq[0].cyc < cyc - 1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sb_stale cyc=%0d got=late exp=%0d", cyc, sbq[0].cyc);
            void'(sbq.pop_front());
        end
        if (sbq.size() > 0 && sbq[0].cyc == cyc - 1) begin
            e = sbq.pop_front();
            chk("pass_cnt",   e.cyc, 32'(pass_cnt),   32'(e.pass));
            chk("fail_cnt",   e.cyc, 32'(fail_cnt),   32'(e.fail));
            chk("sticky",     e.cyc, 32'(sticky),     32'(e.sticky));
            chk("first_vld",  e.cyc, 32'(first_vld),  32'(e.fvld));
            chk("first_ch",   e.cyc, 32'(first_ch),   32'(e.fch));
            chk("first_code", e.cyc, 32'(first_code), 32'(e.fcode));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int waited;
        @(posedge clk);
        #1;
        repeat (3) tick(1, 0);
        tick(0, 0);

        // Single-channel directed outcomes.
        set_plan(0, 8'hA5, 0, 0, 0, 0);  tick(0, 0);   // clean, no flags: pass
        set_plan(0, 8'h5A, 1, 2, 0, 0);  tick(0, 0);   // data bit flipped, corrected: pass
        set_plan(0, 8'h33, 1, 1, 0, 3);  tick(0, 0);   // parity bit with sb_fix: F_FIX first
        set_plan(0, 8'h44, 1, 12, 0, 0); tick(0, 0);   // P0 flipped, sb_err=0: pass
        set_plan(0, 8'h44, 1, 12, 0, 1); tick(0, 0);   // P0 flipped, sb_err=1: F_SB
        set_plan(0, 8'hC3, 2, 3, 7, 0);  tick(0, 0);   // double error flagged: pass
        set_plan(0, 8'hC3, 2, 3, 7, 2);  tick(0, 0);   // double error missed: F_DATA
        repeat (LAT + 1) tick(0, 0);
        tick(0, 1);

        // Simultaneous fails on channels 2 and 3; channel 1 passes.
        set_plan(1, 8'h11, 0, 0, 0, 0);
        set_plan(2, 8'h22, 0, 0, 0, 1);
        set_plan(3, 8'h33, 1, 5, 0, 4);
        tick(0, 0);
        repeat (LAT + 1) tick(0, 0);

        // Missing decoder response.
        set_plan(0, 8'h77, 0, 0, 0, 5);
        repeat (LAT + 2) tick(0, 0);

        // Clear coincident with a failing check.
        set_plan(1, 8'h99, 1, 4, 0, 3);
        tick(0, 0);
        repeat (LAT - 1) tick(0, 0);
        tick(0, 1);
        repeat (LAT + 1) tick(0, 0);

        // Random traffic long enough to saturate both counters.
        spur_pct = 3;
        for (int i = 0; i < 200; i++) begin
            for (int c = 0; c < CH; c++) rand_plan(c, 15);
            tick(0, 0);
        end

        // Random traffic with occasional clear and mid-stream reset.
        for (int i = 0; i < 300; i++) begin
            int r;
            for (int c = 0; c < CH; c++) rand_plan(c, 15);
            r = $urandom_range(0, 99);
            tick(r == 0, r == 1);
        end

        spur_pct = 0;
        repeat (LAT + 2) tick(0, 0);

        waited = 0;
        while (sbq.size() != 0 && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        if (sbq.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain cyc=%0d got=%0d pending exp=0", cyc, sbq.size());
        end
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
